// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program load, decode handshake, SRAM port and IF/ID outputs.
// master = fetch stage, slave = surrounding core / memory.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  loadValid;
    logic [DATA_WIDTH-1:0] loadData;
    logic                  start;
    logic                  stall;
    logic                  branchTaken;
    logic [ADDR_WIDTH-1:0] branchTarget;
    logic [ADDR_WIDTH-1:0] sramAddress;
    logic [DATA_WIDTH-1:0] sramInputData;
    logic                  sramWriteEnable;
    logic [DATA_WIDTH-1:0] sramOutputData;
    logic [DATA_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0] instrPC;
    logic                  instrValid;
    logic [1:0]            state;
    logic                  halted;

    modport master (
        input  loadValid, loadData, start, stall, branchTaken, branchTarget, sramOutputData,
        output sramAddress, sramInputData, sramWriteEnable, instruction, instrPC, instrValid,
               state, halted
    );

    modport slave (
        output loadValid, loadData, start, stall, branchTaken, branchTarget, sramOutputData,
        input  sramAddress, sramInputData, sramWriteEnable, instruction, instrPC, instrValid,
               state, halted
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: loads a program into SRAM, then fetches one word per cycle
// into the IF/ID register with stall, branch flush and halt-opcode stop.
module instruction_fetch #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]            HALT_OPCODE = 6'b111111
) (
    input logic                 Clk,
    input logic                 Reset,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } stateType;

    stateType              curState, nextState;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] loadPtr;
    logic                  advance;
    logic                  fetchHalt;

    assign advance   = (curState == RUN) && !bus.branchTaken && !bus.stall;
    assign fetchHalt = bus.sramOutputData[DATA_WIDTH-1 -: 6] == HALT_OPCODE;

    assign bus.state  = curState;
    assign bus.halted = (curState == HALT);

    always_ff @(posedge Clk) begin
        if (Reset) curState <= IDLE;
        else       curState <= nextState;
    end

    always_comb begin
        nextState           = curState;
        bus.sramAddress     = pc;
        bus.sramInputData   = '0;
        bus.sramWriteEnable = 1'b0;
        case (curState)
            IDLE, LOAD: begin
                bus.sramAddress     = loadPtr;
                bus.sramInputData   = bus.loadData;
                bus.sramWriteEnable = bus.loadValid;
                // A word offered alongside start is still written before running.
                if (bus.start)          nextState = RUN;
                else if (bus.loadValid) nextState = LOAD;
            end
            RUN: begin
                if (advance && fetchHalt) nextState = HALT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc              <= RESET_PC;
            loadPtr         <= '0;
            bus.instruction <= '0;
            bus.instrPC     <= '0;
            bus.instrValid  <= 1'b0;
        end else begin
            case (curState)
                IDLE, LOAD: begin
                    if (bus.loadValid) loadPtr <= loadPtr + 1'b1;
                    if (bus.start)     pc      <= RESET_PC;
                end
                RUN: begin
                    // Branch flushes the IF/ID slot even while decode is stalled.
                    if (bus.branchTaken) begin
                        pc             <= bus.branchTarget;
                        bus.instrValid <= 1'b0;
                    end else if (!bus.stall) begin
                        bus.instruction <= bus.sramOutputData;
                        bus.instrPC     <= pc;
                        bus.instrValid  <= 1'b1;
                        if (!fetchHalt) pc <= pc + 1'b1;
                    end
                end
                HALT: bus.instrValid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural SRAM plus a word-level reference model
// of the fetch rules, directed scenarios and a randomized run.
module tb_instruction_fetch;
    localparam int AW = 16;
    localparam int DW = 32;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    instruction_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

    instruction_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (ifc)
    );

    logic          lv = 1'b0, st = 1'b0, stl = 1'b0, br = 1'b0;
    logic [DW-1:0] ld = '0;
    logic [AW-1:0] bt = '0;
    assign ifc.loadValid    = lv;
    assign ifc.loadData     = ld;
    assign ifc.start        = st;
    assign ifc.stall        = stl;
    assign ifc.branchTaken  = br;
    assign ifc.branchTarget = bt;

    // Basic_SRAM: combinational read, write on rising edge
    logic [DW-1:0] sram [0:65535];
    assign ifc.sramOutputData = sram[ifc.sramAddress];
    always @(posedge Clk) if (ifc.sramWriteEnable) sram[ifc.sramAddress] <= ifc.sramInputData;

    int weCount = 0;
    always @(posedge Clk) if (ifc.sramWriteEnable === 1'b1) weCount++;

    int checks = 0;
    int failures = 0;

    // reference model: mode 0 idle, 1 load, 2 run, 3 halt
    logic [1:0]    mMode;
    logic [AW-1:0] mPc, mPtr, mIPc;
    logic [DW-1:0] mInstr;
    logic          mValid;
    logic [DW-1:0] refMem [0:65535];

    task automatic modelEdge();
        logic [DW-1:0] w;
        if (Reset) begin
            mMode = 0; mPc = 0; mPtr = 0; mInstr = 0; mIPc = 0; mValid = 0;
        end else if (mMode <= 2'd1) begin
            if (lv) begin
                refMem[mPtr] = ld;
                mPtr = mPtr + 1;
            end
            if (st) begin
                mMode = 2; mPc = 0;
            end else if (lv) mMode = 1;
        end else if (mMode == 2'd2) begin
            if (br) begin
                mPc = bt; mValid = 0;
            end else if (!stl) begin
                w = refMem[mPc];
                mInstr = w; mIPc = mPc; mValid = 1;
                if (w[31:26] == 6'h3f) mMode = 3;
                else mPc = mPc + 1;
            end
        end else mValid = 0;
    endtask

    task automatic setIn(input logic l, input logic [DW-1:0] d, input logic s, input logic t,
                         input logic b, input logic [AW-1:0] g, input logic r);
        lv = l; ld = d; st = s; stl = t; br = b; bt = g; Reset = r;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        modelEdge();
        @(negedge Clk);
    endtask

    function automatic logic [DW-1:0] randWord(input logic allowHalt);
        logic [DW-1:0] w;
        w = $urandom;
        if (allowHalt && ($urandom_range(0, 11) == 0)) w[31:26] = 6'h3f;
        else if (w[31:26] == 6'h3f) w[31] = 1'b0;
        return w;
    endfunction

    task automatic loadProgram(input int n);
        setIn(0, 0, 0, 0, 0, 0, 1); tick();
        for (int i = 0; i < n; i++) begin
            setIn(1, randWord(1'b0), 0, 0, 0, 0, 0); tick();
        end
        setIn(0, 0, 1, 0, 0, 0, 0); tick();
    endtask

    task automatic test_reset();
        setIn(0, 0, 0, 0, 0, 0, 1); tick();
        checks++;
        if (ifc.state !== 2'd0 || ifc.halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got state=%0d halted=%b want 0/0", ifc.state, ifc.halted);
        end
        checks++;
        if ({ifc.instrValid, ifc.instrPC, ifc.instruction} !== 49'd0) begin
            failures++;
            $display("FAIL reset_regs got v=%b pc=%h ins=%h want zeros", ifc.instrValid, ifc.instrPC, ifc.instruction);
        end
        setIn(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ifc.sramAddress !== 16'd0 || ifc.sramWriteEnable !== 1'b0) begin
            failures++;
            $display("FAIL reset_sram got addr=%h we=%b want 0/0", ifc.sramAddress, ifc.sramWriteEnable);
        end
    endtask

    logic [DW-1:0] prog [3];

    task automatic test_load();
        prog[0] = 32'h48000400; prog[1] = 32'h00000001; prog[2] = 32'hFC000000;
        weCount = 0;
        for (int i = 0; i < 3; i++) begin
            setIn(1, prog[i], 0, 0, 0, 0, 0);
            checks++;
            if (ifc.sramAddress !== AW'(i) || ifc.sramWriteEnable !== 1'b1 || ifc.sramInputData !== prog[i]) begin
                failures++;
                $display("FAIL load_port i=%0d got addr=%h we=%b data=%h want %h/1/%h",
                         i, ifc.sramAddress, ifc.sramWriteEnable, ifc.sramInputData, i, prog[i]);
            end
            tick();
        end
        setIn(0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (ifc.state !== 2'd1 || ifc.sramAddress !== 16'd3 || ifc.sramWriteEnable !== 1'b0) begin
            failures++;
            $display("FAIL load_done got state=%0d ptr=%h we=%b want 1/3/0", ifc.state, ifc.sramAddress, ifc.sramWriteEnable);
        end
        checks++;
        if (weCount !== 3) begin
            failures++;
            $display("FAIL load_we_count got %0d want 3", weCount);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sram[i] !== prog[i]) begin
                failures++;
                $display("FAIL load_mem addr=%0d got %h want %h", i, sram[i], prog[i]);
            end
        end
    endtask

    task automatic test_run_halt();
        setIn(0, 0, 1, 0, 0, 0, 0); tick();
        setIn(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ifc.state !== 2'd2 || ifc.instrValid !== 1'b0 || ifc.sramAddress !== 16'd0) begin
            failures++;
            $display("FAIL run_start got state=%0d v=%b addr=%h want 2/0/0", ifc.state, ifc.instrValid, ifc.sramAddress);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ifc.instrValid !== 1'b1 || ifc.instrPC !== AW'(i) || ifc.instruction !== prog[i] ||
                ifc.state !== ((i == 2) ? 2'd3 : 2'd2)) begin
                failures++;
                $display("FAIL run_fetch i=%0d got v=%b pc=%h ins=%h state=%0d", i, ifc.instrValid,
                         ifc.instrPC, ifc.instruction, ifc.state);
            end
        end
        tick();
        checks++;
        if (ifc.instrValid !== 1'b0 || ifc.halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_settle got v=%b halted=%b want 0/1", ifc.instrValid, ifc.halted);
        end
        setIn(1, 32'h12345678, 1, 0, 1, 16'h0005, 0);
        checks++;
        if (ifc.sramWriteEnable !== 1'b0) begin
            failures++;
            $display("FAIL halt_we got %b want 0", ifc.sramWriteEnable);
        end
        tick();
        checks++;
        if (ifc.state !== 2'd3 || ifc.instrValid !== 1'b0 || ifc.instruction !== prog[2] || ifc.instrPC !== 16'd2) begin
            failures++;
            $display("FAIL halt_hold got state=%0d v=%b pc=%h ins=%h", ifc.state, ifc.instrValid, ifc.instrPC, ifc.instruction);
        end
    endtask

    task automatic test_stall();
        loadProgram(6);
        setIn(0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            setIn(0, 0, 0, 1, 0, 0, 0);
            checks++;
            if (ifc.sramAddress !== 16'd1) begin
                failures++;
                $display("FAIL stall_addr cyc=%0d got %h want 0001", i, ifc.sramAddress);
            end
            tick();
            checks++;
            if (ifc.instrValid !== 1'b1 || ifc.instrPC !== 16'd0 || ifc.instruction !== refMem[0]) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got v=%b pc=%h ins=%h want 1/0000/%h", i, ifc.instrValid,
                         ifc.instrPC, ifc.instruction, refMem[0]);
            end
        end
        setIn(0, 0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (ifc.instrPC !== 16'd1 || ifc.instruction !== refMem[1]) begin
            failures++;
            $display("FAIL stall_release got pc=%h ins=%h want 0001/%h", ifc.instrPC, ifc.instruction, refMem[1]);
        end
    endtask

    task automatic test_branch();
        loadProgram(32);
        setIn(0, 0, 0, 0, 0, 0, 0); tick();
        setIn(0, 0, 0, 1, 1, 16'h0010, 0); tick();
        setIn(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ifc.instrValid !== 1'b0 || ifc.sramAddress !== 16'h0010) begin
            failures++;
            $display("FAIL branch_flush got v=%b addr=%h want 0/0010", ifc.instrValid, ifc.sramAddress);
        end
        tick();
        checks++;
        if (ifc.instrValid !== 1'b1 || ifc.instrPC !== 16'h0010 || ifc.instruction !== refMem[16]) begin
            failures++;
            $display("FAIL branch_target got v=%b pc=%h ins=%h want 1/0010/%h", ifc.instrValid,
                     ifc.instrPC, ifc.instruction, refMem[16]);
        end
        // reset in the middle of a run clears the IF/ID register
        setIn(0, 0, 0, 0, 0, 0, 1); tick();
        setIn(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({ifc.state, ifc.instrValid, ifc.instrPC, ifc.instruction, ifc.sramAddress} !== 67'd0) begin
            failures++;
            $display("FAIL reset_midrun got state=%0d v=%b pc=%h ins=%h addr=%h want zeros", ifc.state,
                     ifc.instrValid, ifc.instrPC, ifc.instruction, ifc.sramAddress);
        end
    endtask

    task automatic test_reset_midload();
        logic [DW-1:0] a, b, c;
        a = randWord(1'b0); b = randWord(1'b0); c = randWord(1'b0);
        setIn(0, 0, 0, 0, 0, 0, 1); tick();
        setIn(1, a, 0, 0, 0, 0, 0); tick();
        setIn(1, b, 0, 0, 0, 0, 0); tick();
        setIn(0, 0, 0, 0, 0, 0, 1); tick();
        setIn(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ifc.state !== 2'd0 || ifc.sramAddress !== 16'd0 || ifc.instrValid !== 1'b0 || ifc.halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_midload got state=%0d ptr=%h v=%b halted=%b want 0/0/0/0", ifc.state,
                     ifc.sramAddress, ifc.instrValid, ifc.halted);
        end
        setIn(1, c, 0, 0, 0, 0, 0); tick();
        checks++;
        if (sram[0] !== c || sram[1] !== b || ifc.sramAddress !== 16'd1) begin
            failures++;
            $display("FAIL reload_mem got m0=%h m1=%h ptr=%h want %h/%h/0001", sram[0], sram[1], ifc.sramAddress, c, b);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] w;
        w = randWord(1'b0);
        sram[65535] = w; refMem[65535] = w;
        setIn(0, 0, 0, 0, 0, 0, 1); tick();
        setIn(0, 0, 1, 0, 0, 0, 0); tick();
        setIn(0, 0, 0, 0, 1, 16'hFFFF, 0); tick();
        setIn(0, 0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (ifc.instrPC !== 16'hFFFF || ifc.instruction !== w || ifc.sramAddress !== 16'h0000) begin
            failures++;
            $display("FAIL pc_wrap got pc=%h ins=%h addr=%h want FFFF/%h/0000", ifc.instrPC, ifc.instruction, ifc.sramAddress, w);
        end
    endtask

    task automatic test_random();
        int n;
        logic l, s, r;
        for (int round = 0; round < 4; round++) begin
            setIn(0, 0, 0, 0, 0, 0, 1); tick();
            n = $urandom_range(3, 40);
            for (int c = 0; c < n + 150; c++) begin
                r = ($urandom_range(0, 96) == 0);
                l = r ? 1'b0 : ((c < n) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1));
                s = (c == n) || ((c > n) && ($urandom_range(0, 5) == 0));
                setIn(l, randWord(1'b1), s, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                      AW'($urandom_range(0, n + 2)), r);
                checks++;
                if (mMode <= 2'd1) begin
                    if ({ifc.sramAddress, ifc.sramWriteEnable, ifc.sramInputData} !== {mPtr, lv, ld}) begin
                        failures++;
                        $display("FAIL rnd_load c=%0d got addr=%h we=%b d=%h want %h/%b/%h", c, ifc.sramAddress,
                                 ifc.sramWriteEnable, ifc.sramInputData, mPtr, lv, ld);
                    end
                end else if (mMode == 2'd2) begin
                    if (ifc.sramAddress !== mPc || ifc.sramWriteEnable !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_fetch c=%0d got addr=%h we=%b want %h/0", c, ifc.sramAddress, ifc.sramWriteEnable, mPc);
                    end
                end else if (ifc.sramWriteEnable !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_halt_we c=%0d got %b want 0", c, ifc.sramWriteEnable);
                end
                tick();
                checks++;
                if ({ifc.state, ifc.halted, ifc.instrValid, ifc.instrPC, ifc.instruction} !==
                    {mMode, mMode == 2'd3, mValid, mIPc, mInstr}) begin
                    failures++;
                    $display("FAIL rnd_regs c=%0d got st=%0d h=%b v=%b pc=%h ins=%h want st=%0d v=%b pc=%h ins=%h",
                             c, ifc.state, ifc.halted, ifc.instrValid, ifc.instrPC, ifc.instruction,
                             mMode, mValid, mIPc, mInstr);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram[i] = '0;
            refMem[i] = '0;
        end
        test_reset();
        test_load();
        test_run_halt();
        test_stall();
        test_branch();
        test_reset_midload();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
